// File: rtl/vector_seq_checker.sv
// vector_seq_checker: on-board stimulus sequencer and result checker for a
// 3-input / 2-output function pair. Sweeps {a,b,c} through 0..7, holds each
// vector for SETTLE_CYCLES clocks, then compares the two implementations'
// outputs for one cycle. It records the number of failing vectors, the first
// failing vector and an overall pass flag.
module vector_seq_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] y_structural,
    input  logic [1:0] y_other,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       mismatch,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Last settle-counter value before the compare cycle.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] VEC_LAST = 3'd7;

    // True when the two implementations disagree on any output bit.
    function automatic logic outputs_differ(input logic [1:0] ys, input logic [1:0] yo);
        return (ys != yo);
    endfunction

    state_t      state_r;
    state_t      state_nxt;
    logic [2:0]  vec_r;
    logic [2:0]  vec_nxt;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt;
    logic        busy_r;
    logic        busy_nxt;
    logic        done_r;
    logic        done_nxt;
    logic        pass_r;
    logic        pass_nxt;
    logic        mismatch_r;
    logic        mismatch_nxt;
    logic [3:0]  err_count_r;
    logic [3:0]  err_count_nxt;
    logic [2:0]  first_fail_r;
    logic [2:0]  first_fail_nxt;
    logic        fail_valid_r;
    logic        fail_valid_nxt;
    logic        diff_s;

    assign diff_s = outputs_differ(y_structural, y_other);

    // Next-state and next-value logic for the sweep controller and result registers.
    always_comb begin
        state_nxt      = state_r;
        vec_nxt        = vec_r;
        cnt_nxt        = cnt_r;
        busy_nxt       = busy_r;
        done_nxt       = 1'b0;
        pass_nxt       = pass_r;
        mismatch_nxt   = 1'b0;
        err_count_nxt  = err_count_r;
        first_fail_nxt = first_fail_r;
        fail_valid_nxt = fail_valid_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                // abort beats start; a start launches a fresh sweep with cleared results
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (start) begin
                    state_nxt      = ST_SETTLE;
                    vec_nxt        = 3'd0;
                    cnt_nxt        = 4'd0;
                    err_count_nxt  = 4'd0;
                    fail_valid_nxt = 1'b0;
                    first_fail_nxt = 3'd0;
                    pass_nxt       = 1'b0;
                    busy_nxt       = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_SETTLE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    vec_nxt   = 3'd0;
                    cnt_nxt   = 4'd0;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt = ST_COMPARE;
                end else begin
                    cnt_nxt = cnt_r + 4'd1;
                end
            end

            ST_COMPARE: begin
                // an abort discards this cycle's comparison entirely
                if (abort) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    vec_nxt   = 3'd0;
                    cnt_nxt   = 4'd0;
                end else begin
                    if (diff_s) begin
                        mismatch_nxt  = 1'b1;
                        err_count_nxt = err_count_r + 4'd1;
                        if (!fail_valid_r) begin
                            first_fail_nxt = vec_r;
                            fail_valid_nxt = 1'b1;
                        end else begin
                            first_fail_nxt = first_fail_r;
                        end
                    end else begin
                        mismatch_nxt = 1'b0;
                    end

                    if (vec_r == VEC_LAST) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        pass_nxt  = (err_count_nxt == 4'd0);
                    end else begin
                        state_nxt = ST_SETTLE;
                        vec_nxt   = vec_r + 3'd1;
                        cnt_nxt   = 4'd0;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Datapath and registered output flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_r        <= 3'd0;
            cnt_r        <= 4'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            mismatch_r   <= 1'b0;
            err_count_r  <= 4'd0;
            first_fail_r <= 3'd0;
            fail_valid_r <= 1'b0;
        end else begin
            vec_r        <= vec_nxt;
            cnt_r        <= cnt_nxt;
            busy_r       <= busy_nxt;
            done_r       <= done_nxt;
            pass_r       <= pass_nxt;
            mismatch_r   <= mismatch_nxt;
            err_count_r  <= err_count_nxt;
            first_fail_r <= first_fail_nxt;
            fail_valid_r <= fail_valid_nxt;
        end
    end

    assign {a, b, c}  = vec_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign mismatch   = mismatch_r;
    assign err_count  = err_count_r;
    assign first_fail = first_fail_r;
    assign fail_valid = fail_valid_r;

endmodule

// File: doc/vector_seq_checker.md
Name: vector_seq_checker

Overview:
- Self-checking stimulus controller for the 3-input / 2-bit-output function pair (structural and alternative implementations).
- Steps {a,b,c} through all 8 input combinations and waits a programmable settle time after each.
- Compares y_structural against y_other and accumulates a mismatch count and the first failing vector.
- Used on-board in place of the hand-written stimulus sequence, with the two implementations driven in parallel from its a/b/c outputs.

Parameters:
- SETTLE_CYCLES, 2, clock cycles the inputs are held before the outputs are compared. Legal range 1..15.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- abort  input  1  synchronous abandon of a sweep; return to IDLE
- y_structural  input  2  output of structural implementation
- y_other  input  2  output of alternative implementation
- a  output  1  stimulus MSB (vec[2])
- b  output  1  stimulus vec[1]
- c  output  1  stimulus LSB (vec[0])
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  high after a completed sweep with zero mismatches; held until next start
- mismatch  output  1  one-cycle pulse in the compare cycle of a failing vector
- err_count  output  4  number of failing vectors in current/last sweep, 0..8
- first_fail  output  3  vec value of first failing vector; valid when fail_valid=1
- fail_valid  output  1  high once any mismatch has been recorded in current/last sweep

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, vec=0, settle counter=0, busy=0, done=0, pass=0, mismatch=0, err_count=0, first_fail=0, fail_valid=0.
- a,b,c are always driven directly from the vec register: {a,b,c}=vec.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE:
  - start=1 -> vec=0, cnt=0, err_count=0, fail_valid=0, first_fail=0, pass=0, busy=1, next SETTLE.
- SETTLE:
  - If cnt==SETTLE_CYCLES-1 -> COMPARE.
  - Otherwise cnt=cnt+1.
- COMPARE (exactly one cycle per vector):
  - Mismatch is defined as y_structural != y_other (all 2 bits compared).
  - On mismatch: mismatch=1 for this cycle and err_count=err_count+1.
  - On mismatch with fail_valid=0: first_fail=vec and fail_valid=1.
  - If vec==7 -> DONE.
  - Otherwise vec=vec+1, cnt=0, next SETTLE.
  - vec never wraps during a sweep.
- DONE:
  - done=1 for exactly one cycle, busy=0, pass=(err_count==0).
  - vec held at 7.
  - Next state is IDLE.
  - start=1 while in DONE behaves as in IDLE, with done still pulsing that cycle.
- Latency: start sampled at edge N -> SETTLE from N+1; COMPARE for vector k at N+1+k*(SETTLE_CYCLES+1)+SETTLE_CYCLES; done high in cycle N+1+8*(SETTLE_CYCLES+1). Default: 25 cycles after start.
- start while busy=1: ignored, no restart.
- abort=1 in SETTLE/COMPARE:
  - Next state IDLE, busy=0, vec=0.
  - No done pulse and no pass.
  - err_count, first_fail and fail_valid keep partial values.
  - abort has priority over a COMPARE result in the same cycle: the comparison is discarded, no mismatch pulse and no count.
- abort and start both high in IDLE: abort wins, stay IDLE.
- err_count saturation is not needed (max 8 fits 4 bits).
- reset_n asserted mid-sweep: immediate return to the reset values above; next sweep requires a new start.
- All outputs are registered except a/b/c, which are register-direct as stated above.

Test Plan:
- Identical implementations, SETTLE_CYCLES=2, start pulse -> vec 0..7 each held 3 cycles; done pulses 25 cycles after start; pass=1, err_count=0, fail_valid=0, mismatch never high.
- y_other forced to differ only when {a,b,c}=3'b011 and 3'b110 -> mismatch pulses in those two COMPARE cycles; err_count=2, first_fail=3, fail_valid=1, pass=0.
- y_other inverted for all vectors -> err_count=8, first_fail=0, pass=0; done still after 25 cycles.
- start re-pulsed at cycle 10 of a sweep -> ignored; done timing unchanged; second start after DONE clears err_count/fail_valid and re-sweeps.
- abort asserted in COMPARE of vec=4 with a mismatch present -> no mismatch pulse, err_count unchanged, busy=0 next cycle, vec=0, no done.
- reset_n pulsed low mid-SETTLE of vec=5 -> all outputs zero asynchronously; start afterwards runs a full sweep from vec=0.
